rsa_engine_arbiter: RTL and testbench
=====================================

Name: rsa_engine_arbiter

Overview:
- Shares one modular-exponentiation engine (exponent-sequencing FSM plus Montgomery multiplier) between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands into the engine operand registers.
- Holds the engine in reset between jobs and releases it to run.
- Returns the result with a done pulse, and aborts or flags a timeout when the engine never asserts end-of-computation.

Parameters:
- WIDTH, 8, operand/result width in bits.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 255, maximum RUN cycles (enabled cycles) before error; must be at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rstb  input  1  reset.
- ena  input  1  clock enable; when 0 all state holds.
- req  input  NREQ  per-requester request; held high until done/err.
- req_msg  input  NREQ*WIDTH  flattened messages; slice i = [i*WIDTH +: WIDTH].
- req_exp  input  NREQ*WIDTH  flattened exponents.
- req_mod  input  NREQ*WIDTH  flattened moduli.
- gnt  output  NREQ  one-hot grant.
- done  output  NREQ  one-cycle completion pulse to the granted requester.
- err  output  NREQ  one-cycle timeout pulse to the granted requester.
- result  output  WIDTH  last completed result.
- busy  output  1  high in every state except IDLE.
- eng_rst_n  output  1  engine reset, active-low.
- eng_msg, eng_exp, eng_mod  output  WIDTH each  latched operands to the engine.
- eng_eoc  input  1  engine end-of-computation.
- eng_result  input  WIDTH  engine result.

Behaviour:
- Reset: rstb is synchronous, active-low. It is sampled on the rising clk edge and overrides ena.
- Reset values:
  - gnt, done, err = 0; result = 0; busy = 0.
  - eng_rst_n = 0; eng_* operands = 0.
  - state = IDLE; timer = 0; last_grant = NREQ-1, so requester 0 wins first.
- ena = 0: every register holds, including state, timer and any done/err pulse. A pulse therefore lasts until the next enabled edge.
- All outputs are registered or decoded from registered state. There is no combinational path from req or eng_eoc to any output.
- Timer width is clog2(TIMEOUT+1).
- IDLE:
  - eng_rst_n = 0, gnt = 0.
  - If any req is high, select the first requester at or after (last_grant+1) mod NREQ, searching upward with wrap.
  - Register the winner's index; go to LOAD.
- LOAD (1 cycle):
  - gnt[idx] = 1; eng_msg/exp/mod load slice idx; timer clears.
  - Go to RUN.
- RUN:
  - eng_rst_n = 1, gnt[idx] = 1, timer increments each enabled cycle.
  - Priorities, highest first:
    - eng_eoc = 1: result <= eng_result; go to DONE.
    - timer == TIMEOUT-1: go to ERR.
    - req[idx] = 0 (abort): go to COOL with no done and no err.
- DONE (1 cycle): done[idx] = 1, gnt[idx] = 1; result is already valid. Go to COOL.
- ERR (1 cycle): err[idx] = 1, gnt[idx] = 1; result is unchanged. Go to COOL.
- COOL (1 cycle):
  - eng_rst_n = 0, gnt = 0, last_grant <= idx.
  - Go to IDLE. This guarantees at least 2 cycles of engine reset between jobs.
- Requests:
  - req changes outside RUN are ignored for the current job.
  - Operands are sampled only in LOAD; later operand changes have no effect.
  - A requester that keeps req high after done re-enters arbitration but yields to any other active requester.
- Simultaneous events: eoc and timeout in the same cycle resolves to DONE. eoc and req drop in the same cycle also resolves to DONE, and done is still pulsed.
- Mid-operation reset: the next edge with rstb = 0 forces reset values, and eng_rst_n drops immediately. No done or err is generated for the lost job.

Test Plan:
- Single job: WIDTH = 8; req[0] with msg = 5, exp = 3, mod = 13; engine model asserts eoc after 20 RUN cycles with result 8.
  - Required: gnt = 01 one cycle after req.
  - Required: eng_rst_n high exactly 20 cycles; done[0] pulses once; result = 8; busy drops 2 cycles after done.
- Round-robin fairness: req = 11 held continuously over 4 jobs.
  - Required grant order: 0, 1, 0, 1; never two consecutive grants to one requester.
- Timeout: TIMEOUT = 16; engine never asserts eoc.
  - Required: err[idx] after exactly 16 RUN cycles; result unchanged; no done; engine reset in COOL.
- Abort: req[1] drops at RUN cycle 5.
  - Required: COOL on the next edge, no done/err, then IDLE; pending req[0] is granted next.
- Priority collision: eoc coincides with timer == TIMEOUT-1, and separately eoc coincides with req drop.
  - Required in both cases: DONE with the correct result and no err.
- Enable/reset: ena = 0 for 7 cycles during RUN.
  - Required: timer and state frozen, then the job resumes and completes.
  - Then assert rstb = 0 mid-RUN: all outputs at reset values after one edge, and the arbitration pointer restarts at requester 0.

Source files
------------

// File: rtl/rsa_engine_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rsa_engine_arbiter_if
// Brief    : Requester-side and engine-side bundle of the RSA engine arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rsa_engine_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    // Requester side
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_msg;
    logic [NREQ*WIDTH-1:0] req_exp;
    logic [NREQ*WIDTH-1:0] req_mod;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       err;
    logic [WIDTH-1:0]      result;
    logic                  busy;

    // Engine side
    logic                  eng_rst_n;
    logic [WIDTH-1:0]      eng_msg;
    logic [WIDTH-1:0]      eng_exp;
    logic [WIDTH-1:0]      eng_mod;
    logic                  eng_eoc;
    logic [WIDTH-1:0]      eng_result;

    modport slave (
        input  req, req_msg, req_exp, req_mod, eng_eoc, eng_result,
        output gnt, done, err, result, busy,
               eng_rst_n, eng_msg, eng_exp, eng_mod
    );

    modport master (
        output req, req_msg, req_exp, req_mod, eng_eoc, eng_result,
        input  gnt, done, err, result, busy,
               eng_rst_n, eng_msg, eng_exp, eng_mod
    );
endinterface
`default_nettype wire

// File: rtl/rsa_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rsa_engine_arbiter
// Brief    : Round-robin sharing of one modular-exponentiation engine among
//            NREQ requesters, with operand latching, engine reset sequencing
//            and a run-time watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_engine_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                ena,
    rsa_engine_arbiter_if.slave bus
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TW = $clog2(TIMEOUT + 1);

    localparam logic [c_TW-1:0] c_TLAST     = c_TW'(TIMEOUT - 1);
    localparam logic [c_IW-1:0] c_LAST_INIT = c_IW'(NREQ - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LOAD = 3'd1;
    localparam logic [2:0] c_RUN  = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;
    localparam logic [2:0] c_COOL = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [c_IW-1:0]  r_idx;
    logic [c_IW-1:0]  r_last;
    logic [c_TW-1:0]  r_timer;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_msg;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_mod;

    logic             w_any;
    logic [c_IW-1:0]  w_pick;
    logic [c_IW-1:0]  w_cand;
    logic [WIDTH-1:0] w_sel_msg;
    logic [WIDTH-1:0] w_sel_exp;
    logic [WIDTH-1:0] w_sel_mod;

    logic [NREQ-1:0]  w_gnt;
    logic [NREQ-1:0]  w_done;
    logic [NREQ-1:0]  w_err;
    logic             w_busy;
    logic             w_eng_rst_n;

    // Search starts just after the previous winner so every active
    // requester is served before any one is served twice.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_last;
        w_cand = '0;
        for (int off = 1; off <= NREQ; off++) begin
            w_cand = c_IW'((int'(r_last) + off) % NREQ);
            if (!w_any && bus.req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_msg = '0;
        w_sel_exp = '0;
        w_sel_mod = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_sel_msg = bus.req_msg[i*WIDTH +: WIDTH];
                w_sel_exp = bus.req_exp[i*WIDTH +: WIDTH];
                w_sel_mod = bus.req_mod[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= c_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    // Next-state logic; end-of-computation outranks both the watchdog and
    // an abort so a finished result is never discarded.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_next = c_LOAD;
                end
            end
            c_LOAD: w_next = c_RUN;
            c_RUN: begin
                if (bus.eng_eoc) begin
                    w_next = c_DONE;
                end else if (r_timer == c_TLAST) begin
                    w_next = c_ERR;
                end else if (!bus.req[r_idx]) begin
                    w_next = c_COOL;
                end
            end
            c_DONE:  w_next = c_COOL;
            c_ERR:   w_next = c_COOL;
            c_COOL:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        w_gnt       = '0;
        w_done      = '0;
        w_err       = '0;
        w_busy      = 1'b1;
        w_eng_rst_n = 1'b0;
        case (r_state)
            c_IDLE: w_busy = 1'b0;
            c_LOAD: w_gnt[r_idx] = 1'b1;
            c_RUN: begin
                w_gnt[r_idx] = 1'b1;
                w_eng_rst_n  = 1'b1;
            end
            c_DONE: begin
                w_gnt[r_idx]  = 1'b1;
                w_done[r_idx] = 1'b1;
            end
            c_ERR: begin
                w_gnt[r_idx] = 1'b1;
                w_err[r_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    // Job datapath: winner index, operands, watchdog, result and pointer
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_idx    <= '0;
            r_last   <= c_LAST_INIT;
            r_timer  <= '0;
            r_result <= '0;
            r_msg    <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
        end else if (ena) begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_idx <= w_pick;
                    end
                end
                c_LOAD: begin
                    r_timer <= '0;
                    r_msg   <= w_sel_msg;
                    r_exp   <= w_sel_exp;
                    r_mod   <= w_sel_mod;
                end
                c_RUN: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.eng_eoc) begin
                        r_result <= bus.eng_result;
                    end
                end
                c_COOL: r_last <= r_idx;
                default: ;
            endcase
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.done      = w_done;
    assign bus.err       = w_err;
    assign bus.busy      = w_busy;
    assign bus.result    = r_result;
    assign bus.eng_rst_n = w_eng_rst_n;
    assign bus.eng_msg   = r_msg;
    assign bus.eng_exp   = r_exp;
    assign bus.eng_mod   = r_mod;

endmodule
`default_nettype wire

// File: tb/tb_rsa_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_engine_arbiter
// Brief    : Scoreboard bench: two arbiters (long and 16-cycle watchdog)
//            driving a behavioural modexp engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_engine_arbiter;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    logic ena  = 1'b1;

    always #5 clk = ~clk;

    rsa_engine_arbiter_if #(.WIDTH(8), .NREQ(2)) bus_a ();
    rsa_engine_arbiter_if #(.WIDTH(8), .NREQ(2)) bus_b ();

    rsa_engine_arbiter #(.WIDTH(8), .NREQ(2), .TIMEOUT(255)) u_dut (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .bus  (bus_a)
    );

    rsa_engine_arbiter #(.WIDTH(8), .NREQ(2), .TIMEOUT(16)) u_dut_to (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .bus  (bus_b)
    );

    // Engine model: asserts eoc in its lat-th enabled run cycle (0 = never)
    int lat_a = 0;
    int lat_b = 0;
    int cnt_a = 0;
    int cnt_b = 0;

    function automatic logic [7:0] modexp(input logic [7:0] m, input logic [7:0] e,
                                          input logic [7:0] n);
        int acc;
        if (n == 8'd0) return 8'd0;
        acc = 1 % int'(n);
        for (int i = 0; i < int'(e); i++) acc = (acc * int'(m)) % int'(n);
        return acc[7:0];
    endfunction

    always @(posedge clk) begin
        if (!bus_a.eng_rst_n) cnt_a <= 0;
        else if (ena) cnt_a <= cnt_a + 1;
        if (!bus_b.eng_rst_n) cnt_b <= 0;
        else if (ena) cnt_b <= cnt_b + 1;
    end

    assign bus_a.eng_eoc    = bus_a.eng_rst_n && (lat_a != 0) && (cnt_a == lat_a - 1);
    assign bus_b.eng_eoc    = bus_b.eng_rst_n && (lat_b != 0) && (cnt_b == lat_b - 1);
    assign bus_a.eng_result = modexp(bus_a.eng_msg, bus_a.eng_exp, bus_a.eng_mod);
    assign bus_b.eng_result = modexp(bus_b.eng_msg, bus_b.eng_exp, bus_b.eng_mod);

    // Scoreboard
    typedef struct {
        int         inst;
        logic [1:0] done;
        logic [1:0] err;
        logic [7:0] res;
    } ev_t;

    typedef struct {
        int inst;
        int idx;
    } gx_t;

    ev_t ev_q[$];
    gx_t gnt_q[$];
    int  errors   = 0;
    int  checks   = 0;
    int  ev_seen  = 0;
    int  gnt_seen = 0;
    logic [1:0] prev_de [2] = '{2'b00, 2'b00};
    logic [1:0] prev_g  [2] = '{2'b00, 2'b00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_ev(input int inst, input logic [1:0] d, input logic [1:0] e,
                           input logic [7:0] r);
        ev_t x;
        x.inst = inst; x.done = d; x.err = e; x.res = r;
        ev_q.push_back(x);
    endtask

    task automatic push_gnt(input int inst, input int idx);
        gx_t y;
        y.inst = inst; y.idx = idx;
        gnt_q.push_back(y);
    endtask

    task automatic mon(input int inst, input logic [1:0] d, input logic [1:0] e,
                       input logic [1:0] g, input logic [7:0] r);
        ev_t x;
        gx_t y;
        logic [1:0] oh;
        if ((d | e) != 2'b00 && prev_de[inst] == 2'b00) begin
            ev_seen++;
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: inst=%0d done=%b err=%b", inst, d, e);
            end else begin
                x = ev_q.pop_front();
                chk("event_inst", inst, x.inst);
                chk("event_done", d, x.done);
                chk("event_err", e, x.err);
                chk("event_result", r, x.res);
            end
        end
        prev_de[inst] = d | e;
        if (g != 2'b00 && prev_g[inst] == 2'b00) begin
            gnt_seen++;
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: inst=%0d gnt=%b", inst, g);
            end else begin
                y  = gnt_q.pop_front();
                oh = 2'b01 << y.idx;
                chk("grant_inst", inst, y.inst);
                chk("grant_vector", g, oh);
            end
        end
        prev_g[inst] = g;
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.done, bus_a.err, bus_a.gnt, bus_a.result);
        mon(1, bus_b.done, bus_b.err, bus_b.gnt, bus_b.result);
    end

    // Stimulus helpers
    task automatic set_ops(input int inst, input int i, input logic [7:0] m,
                           input logic [7:0] e, input logic [7:0] n);
        if (inst == 0) begin
            bus_a.req_msg[i*8 +: 8] = m;
            bus_a.req_exp[i*8 +: 8] = e;
            bus_a.req_mod[i*8 +: 8] = n;
        end else begin
            bus_b.req_msg[i*8 +: 8] = m;
            bus_b.req_exp[i*8 +: 8] = e;
            bus_b.req_mod[i*8 +: 8] = n;
        end
    endtask

    task automatic wait_grant(input int base);
        int k = 0;
        while (gnt_seen == base && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        chk("grant_arrived", gnt_seen > base, 1);
    endtask

    // Returns the number of cycles the selected engine was out of reset
    task automatic wait_ev(input int inst, output int run);
        int base = ev_seen;
        int k    = 0;
        run = 0;
        while (ev_seen == base && k < 400) begin
            @(negedge clk); #1;
            if ((inst == 0) ? bus_a.eng_rst_n : bus_b.eng_rst_n) run++;
            k++;
        end
        chk("event_arrived", ev_seen > base, 1);
    endtask

    task automatic do_reset();
        @(negedge clk); rstb = 1'b0;
        @(negedge clk); rstb = 1'b1;
    endtask

    int run;
    int gb;

    initial begin
        bus_a.req = '0; bus_a.req_msg = '0; bus_a.req_exp = '0; bus_a.req_mod = '0;
        bus_b.req = '0; bus_b.req_msg = '0; bus_b.req_exp = '0; bus_b.req_mod = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", bus_a.gnt, 0);
        chk("rst_done_err", {bus_a.done, bus_a.err}, 0);
        chk("rst_result", bus_a.result, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_eng_rst_n", bus_a.eng_rst_n, 0);
        chk("rst_operands", {bus_a.eng_msg, bus_a.eng_exp, bus_a.eng_mod}, 0);
        rstb = 1'b1;

        // Single job: 5^3 mod 13 = 8, engine needs 20 run cycles
        @(negedge clk);
        lat_a = 20;
        set_ops(0, 0, 8'd5, 8'd3, 8'd13);
        push_gnt(0, 0);
        push_ev(0, 2'b01, 2'b00, 8'd8);
        bus_a.req = 2'b01;
        @(negedge clk); #1;
        chk("single_gnt_latency", bus_a.gnt, 2'b01);
        wait_ev(0, run);
        chk("single_run_cycles", run, 20);
        bus_a.req = 2'b00;
        @(negedge clk); #1;
        chk("single_cool_busy", bus_a.busy, 1);
        chk("single_cool_eng_rst", bus_a.eng_rst_n, 0);
        @(negedge clk); #1;
        chk("single_busy_drop", bus_a.busy, 0);

        // Fairness: both requesters held over four jobs after a pointer reset
        do_reset();
        lat_a = 6;
        set_ops(0, 0, 8'd5, 8'd3, 8'd13);
        set_ops(0, 1, 8'd7, 8'd2, 8'd11);
        push_gnt(0, 0); push_ev(0, 2'b01, 2'b00, 8'd8);
        push_gnt(0, 1); push_ev(0, 2'b10, 2'b00, 8'd5);
        push_gnt(0, 0); push_ev(0, 2'b01, 2'b00, 8'd8);
        push_gnt(0, 1); push_ev(0, 2'b10, 2'b00, 8'd5);
        bus_a.req = 2'b11;
        for (int j = 0; j < 4; j++) wait_ev(0, run);
        bus_a.req = 2'b00;
        repeat (3) @(negedge clk);

        // Abort: requester 1 drops in run cycle 5, pending requester 0 follows
        lat_a = 0;
        push_gnt(0, 1);
        gb = gnt_seen;
        bus_a.req = 2'b10;
        wait_grant(gb);
        bus_a.req[0] = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("abort_in_run", bus_a.eng_rst_n, 1);
        bus_a.req[1] = 1'b0;
        lat_a = 6;
        push_gnt(0, 0);
        push_ev(0, 2'b01, 2'b00, 8'd8);
        @(negedge clk); #1;
        chk("abort_cool_busy", bus_a.busy, 1);
        chk("abort_cool_gnt", bus_a.gnt, 0);
        chk("abort_cool_eng_rst", bus_a.eng_rst_n, 0);
        @(negedge clk); #1;
        chk("abort_idle", bus_a.busy, 0);
        wait_ev(0, run);
        bus_a.req = 2'b00;
        repeat (3) @(negedge clk);

        // eoc in the same cycle as the watchdog limit (16-cycle instance)
        lat_b = 16;
        set_ops(1, 0, 8'd2, 8'd5, 8'd13);
        push_gnt(1, 0);
        push_ev(1, 2'b01, 2'b00, 8'd6);
        gb = gnt_seen;
        bus_b.req = 2'b01;
        wait_grant(gb);
        wait_ev(1, run);
        chk("collide_to_run", run, 16);
        bus_b.req = 2'b00;
        repeat (3) @(negedge clk);

        // Timeout: engine silent, err after 16 run cycles, result kept
        lat_b = 0;
        set_ops(1, 1, 8'd7, 8'd2, 8'd11);
        push_gnt(1, 1);
        push_ev(1, 2'b00, 2'b10, 8'd6);
        gb = gnt_seen;
        bus_b.req = 2'b10;
        wait_grant(gb);
        wait_ev(1, run);
        chk("timeout_run", run, 16);
        bus_b.req = 2'b00;
        @(negedge clk); #1;
        chk("timeout_cool_eng_rst", bus_b.eng_rst_n, 0);
        chk("timeout_cool_busy", bus_b.busy, 1);
        repeat (3) @(negedge clk);

        // eoc in the same cycle as the request drop
        lat_a = 8;
        set_ops(0, 0, 8'd3, 8'd4, 8'd7);
        push_gnt(0, 0);
        push_ev(0, 2'b01, 2'b00, 8'd4);
        gb = gnt_seen;
        bus_a.req = 2'b01;
        wait_grant(gb);
        repeat (8) @(negedge clk);
        #1;
        chk("collide_drop_eoc", bus_a.eng_eoc, 1);
        bus_a.req = 2'b00;
        wait_ev(0, run);
        repeat (3) @(negedge clk);

        // Clock enable low for 7 cycles in the middle of a 10-cycle job
        lat_a = 10;
        push_gnt(0, 0);
        push_ev(0, 2'b01, 2'b00, 8'd4);
        gb = gnt_seen;
        bus_a.req = 2'b01;
        wait_grant(gb);
        repeat (3) @(negedge clk);
        ena = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); #1;
            chk("freeze_state", {bus_a.eng_rst_n, bus_a.gnt, bus_a.done}, {1'b1, 2'b01, 2'b00});
        end
        ena = 1'b1;
        wait_ev(0, run);
        chk("freeze_total_run", 3 + 7 + run, 17);
        bus_a.req = 2'b00;
        repeat (3) @(negedge clk);

        // Reset in the middle of a job for requester 1
        lat_a = 0;
        set_ops(0, 0, 8'd5, 8'd3, 8'd13);
        push_gnt(0, 1);
        gb = gnt_seen;
        bus_a.req = 2'b10;
        wait_grant(gb);
        repeat (4) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk); #1;
        chk("midrst_gnt", bus_a.gnt, 0);
        chk("midrst_done_err", {bus_a.done, bus_a.err}, 0);
        chk("midrst_result", bus_a.result, 0);
        chk("midrst_busy", bus_a.busy, 0);
        chk("midrst_eng_rst_n", bus_a.eng_rst_n, 0);
        chk("midrst_operands", {bus_a.eng_msg, bus_a.eng_exp, bus_a.eng_mod}, 0);
        rstb  = 1'b1;
        lat_a = 5;
        push_gnt(0, 0); push_ev(0, 2'b01, 2'b00, 8'd8);
        push_gnt(0, 1); push_ev(0, 2'b10, 2'b00, 8'd5);
        bus_a.req = 2'b11;
        wait_ev(0, run);
        wait_ev(0, run);
        bus_a.req = 2'b00;
        repeat (5) @(negedge clk);

        chk("events_outstanding", ev_q.size(), 0);
        chk("grants_outstanding", gnt_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
